// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one byte-level UART TX between N_REQ requesters.
// Define UART_ARB_WDOG_EN to add a tx_busy watchdog in WAIT_BUSY.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 8680,
    parameter int WDOG_CYCLES = 16
) (
    input  logic               clk_100MHz,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   last,
    input  logic [8*N_REQ-1:0] data,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   grant,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    output logic               err,
    output logic [2:0]         state_dbg
);
    localparam int IDXW = $clog2(N_REQ);
    localparam int HCW  = $clog2(HOLD_CYCLES);

    // Handshake: requester i holds req[i] (with data/last) until ack[i] pulses for one
    // cycle; the byte counts as consumed on that pulse. tx_start is a one-cycle strobe
    // issued only while tx_busy is low; tx_busy high marks the frame in flight.

    if (N_REQ < 2 || N_REQ > 8 || HOLD_CYCLES < 2 || WDOG_CYCLES < 1) begin : g_bad_param
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        HOLD      = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [IDXW-1:0]   owner, owner_n;
    logic [IDXW-1:0]   last_owner, last_owner_n;
    logic              lock, lock_n;
    logic [HCW-1:0]    hold_cnt, hold_cnt_n;
    logic [N_REQ-1:0]  ack_n, grant_n;
    logic              tx_start_n, err_n;
    logic [7:0]        tx_data_n;
    logic              pick_found;
    logic [IDXW-1:0]   pick_idx, cand;

`ifdef UART_ARB_WDOG_EN
    localparam int WCW = $clog2(WDOG_CYCLES + 1);
    logic [WCW-1:0]    wdog_cnt, wdog_cnt_n;
`endif

    // Rotating search starting just after the previous packet's owner.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDXW'((int'(last_owner) + i) % N_REQ);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_owner_n = last_owner;
        lock_n       = lock;
        hold_cnt_n   = hold_cnt;
        ack_n        = '0;
        grant_n      = grant;
        tx_start_n   = 1'b0;
        tx_data_n    = tx_data;
        err_n        = 1'b0;
`ifdef UART_ARB_WDOG_EN
        wdog_cnt_n   = wdog_cnt;
`endif
        case (state)
            IDLE: begin
                if (pick_found) begin
                    owner_n = pick_idx;
                    grant_n = N_REQ'(1) << pick_idx;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                tx_start_n = 1'b1;
                ack_n      = N_REQ'(1) << owner;
                tx_data_n  = data[{owner, 3'b000} +: 8];
                lock_n     = ~last[owner];
                state_n    = WAIT_BUSY;
`ifdef UART_ARB_WDOG_EN
                wdog_cnt_n = '0;
`endif
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_n = WAIT_DONE;
`ifdef UART_ARB_WDOG_EN
                end else if (wdog_cnt == WCW'(WDOG_CYCLES - 1)) begin
                    err_n        = 1'b1;
                    lock_n       = 1'b0;
                    last_owner_n = owner;
                    grant_n      = '0;
                    state_n      = IDLE;
                end else begin
                    wdog_cnt_n = wdog_cnt + 1'b1;
`endif
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (lock && req[owner]) begin
                        state_n = LOAD;
                    end else if (lock) begin
                        hold_cnt_n = '0;
                        state_n    = HOLD;
                    end else begin
                        last_owner_n = owner;
                        grant_n      = '0;
                        state_n      = IDLE;
                    end
                end
            end
            HOLD: begin
                if (req[owner]) begin
                    state_n = LOAD;
                end else if (hold_cnt == HCW'(HOLD_CYCLES - 1)) begin
                    // Stalled mid-packet: give the link to the others.
                    err_n        = 1'b1;
                    last_owner_n = owner;
                    grant_n      = '0;
                    state_n      = IDLE;
                end else begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IDXW'(N_REQ - 1);
            lock       <= 1'b0;
            hold_cnt   <= '0;
            ack        <= '0;
            grant      <= '0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            err        <= 1'b0;
`ifdef UART_ARB_WDOG_EN
            wdog_cnt   <= '0;
`endif
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_owner_n;
            lock       <= lock_n;
            hold_cnt   <= hold_cnt_n;
            ack        <= ack_n;
            grant      <= grant_n;
            tx_start   <= tx_start_n;
            tx_data    <= tx_data_n;
            err        <= err_n;
`ifdef UART_ARB_WDOG_EN
            wdog_cnt   <= wdog_cnt_n;
`endif
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: packet-level queue model plus per-cycle compare.
// Watchdog expectations follow UART_ARB_WDOG_EN.
module tb_uart_tx_arbiter;
    localparam int N        = 4;
    localparam int HOLD_C   = 8680;
    localparam int WDOG_C   = 16;
    localparam int BUSY_LEN = 20;
    localparam int W        = 11;
    localparam int LIMIT    = 20000;

    logic           clk_100MHz = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   last = '0;
    logic [8*N-1:0] data = '0;
    logic           tx_busy = 1'b0;
    logic [N-1:0]   ack, grant;
    logic           tx_start, err;
    logic [7:0]     tx_data;
    logic [2:0]     state_dbg;

    always #5 clk_100MHz = ~clk_100MHz;

    uart_tx_arbiter #(.N_REQ(N), .HOLD_CYCLES(HOLD_C), .WDOG_CYCLES(WDOG_C)) dut (
        .clk_100MHz(clk_100MHz), .rst(rst), .req(req), .last(last), .data(data),
        .ack(ack), .grant(grant), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .err(err), .state_dbg(state_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;
    int err_seen = 0;
    int err_exp  = 0;
    bit chk_en   = 1'b0;
    bit tx_en    = 1'b1;
    logic [W-1:0] exp_q[$];

    // Per-requester byte sources: {last, data}.
    logic [8:0] src_mem [N][16];
    int src_head [N] = '{default: 0};
    int src_tail [N] = '{default: 0};
    int m_head   [N] = '{default: 0};
    int m_lo = N - 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [N-1:0] oh(input logic [2:0] i);
        return 4'b0001 << i;
    endfunction

    task automatic push(input int r, input logic [7:0] d, input logic l);
        src_mem[r][src_tail[r]] = {l, d};
        src_tail[r]++;
    endtask

    // Packet-level model: serve pending packets in rotating order from the last owner;
    // a packet whose bytes run out before a last byte ends in a hold timeout.
    task automatic run_model();
        bit more = 1'b1;
        bit found, done;
        int r;
        logic [8:0] e;
        while (more) begin
            found = 1'b0;
            r = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && m_head[(m_lo + k) % N] < src_tail[(m_lo + k) % N]) begin
                    found = 1'b1;
                    r = (m_lo + k) % N;
                end
            end
            if (!found) begin
                more = 1'b0;
            end else begin
                done = 1'b0;
                while (!done) begin
                    if (m_head[r] == src_tail[r]) begin
                        err_exp++;
                        done = 1'b1;
                    end else begin
                        e = src_mem[r][m_head[r]];
                        m_head[r]++;
                        exp_q.push_back({3'(r), e[7:0]});
                        if (e[8]) done = 1'b1;
                    end
                end
                m_lo = r;
            end
        end
    endtask

    // Requester and UART TX drivers: observe at negedge, act just after the next posedge.
    initial begin
        logic [N-1:0] ack_seen;
        logic start_seen;
        int busy_cnt = 0;
        forever begin
            @(negedge clk_100MHz);
            ack_seen   = ack;
            start_seen = tx_start;
            @(posedge clk_100MHz);
            #2;
            for (int i = 0; i < N; i++) begin
                if (ack_seen[i] && src_head[i] < src_tail[i]) src_head[i]++;
                req[i] = (src_head[i] < src_tail[i]);
                if (req[i]) begin
                    data[8*i +: 8] = src_mem[i][src_head[i]][7:0];
                    last[i] = src_mem[i][src_head[i]][8];
                end else begin
                    last[i] = 1'b0;
                end
            end
            if (start_seen && tx_en) begin
                busy_cnt = BUSY_LEN;
                tx_busy = 1'b1;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
        end
    end

    // Scoreboard compare, every cycle outside reset.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk_100MHz);
            if (chk_en && !rst) begin
                chk("grant_onehot0", $onehot0(grant), 1);
                if (err) err_seen++;
                if (tx_start) begin
                    chk("start_while_busy", tx_busy, 0);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_tx_start: got data %0h ack %0h expected none", tx_data, ack);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_data", tx_data, e[7:0]);
                        chk("ack_owner", ack, oh(e[10:8]));
                        chk("grant_owner", grant, oh(e[10:8]));
                    end
                end else begin
                    chk("ack_without_start", ack, 0);
                end
            end
        end
    end

    task automatic wait_cond(input int which, input logic level, input string name);
        int t = 0;
        logic v;
        forever begin
            case (which)
                0:       v = tx_busy;
                1:       v = tx_start;
                default: v = req[0];
            endcase
            if (v === level || t >= LIMIT) break;
            @(negedge clk_100MHz);
            t++;
        end
        if (t >= LIMIT) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: timeout after %0d cycles, expected level %0d", name, t, level);
        end
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (!(exp_q.size() == 0 && grant == '0 && !tx_busy) && t < LIMIT) begin
            @(negedge clk_100MHz);
            t++;
        end
        if (t >= LIMIT) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: drain timeout, %0d bytes still expected", name, exp_q.size());
        end
        chk({name, "_err_count"}, err_seen, err_exp);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk_100MHz);
        chk("rst_grant", grant, 0);
        chk("rst_ack", ack, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_err", err, 0);
        chk("rst_state", state_dbg, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Single byte: latency, grant lifetime, held tx_data.
        push(0, 8'hA5, 1'b1);
        run_model();
        wait_cond(2, 1'b1, "t1_req0");
        @(negedge clk_100MHz);
        chk("t1_grant_early", grant, 4'b0001);
        chk("t1_no_start_yet", tx_start, 0);
        @(negedge clk_100MHz);
        chk("t1_start", tx_start, 1);
        chk("t1_ack", ack, 4'b0001);
        chk("t1_data", tx_data, 8'hA5);
        wait_cond(0, 1'b1, "t1_busy_rise");
        wait_cond(0, 1'b0, "t1_busy_fall");
        chk("t1_grant_held", grant, 4'b0001);
        @(negedge clk_100MHz);
        chk("t1_grant_released", grant, 0);
        chk("t1_data_held", tx_data, 8'hA5);
        wait_drain("t1");

        // All four requesting after reset: order 0,1,2,3,0.
        @(negedge clk_100MHz); rst = 1'b1;
        repeat (2) @(negedge clk_100MHz);
        rst = 1'b0;
        m_lo = N - 1;
        push(0, 8'h11, 1'b1); push(1, 8'h22, 1'b1); push(2, 8'h33, 1'b1);
        push(3, 8'h44, 1'b1); push(0, 8'h55, 1'b1);
        run_model();
        chk("t2_model_len", exp_q.size(), 5);
        chk("t2_model_first", exp_q[0], {3'd0, 8'h11});
        chk("t2_model_fifth", exp_q[4], {3'd0, 8'h55});
        wait_drain("t2");

        // Three-byte packet from 1 locks out requester 2.
        push(2, 8'h77, 1'b1);
        push(1, 8'h61, 1'b0); push(1, 8'h62, 1'b0); push(1, 8'h63, 1'b1);
        run_model();
        chk("t3_model_fourth", exp_q[3], {3'd2, 8'h77});
        wait_drain("t3");

        // Stalled packet from 0: hold timeout, then requester 1.
        push(0, 8'hC0, 1'b0);
        push(1, 8'hC1, 1'b1);
        run_model();
        chk("t4_model_err", err_exp, 1);
        wait_cond(0, 1'b1, "t4_busy_rise");
        wait_cond(0, 1'b0, "t4_busy_fall");
        t = 0;
        while (!err && t < HOLD_C + 50) begin
            @(negedge clk_100MHz);
            t++;
        end
        chk("t4_hold_len", t, HOLD_C + 1);
        chk("t4_grant_at_err", grant, 0);
        wait_drain("t4");

        // Reset during WAIT_DONE; afterwards requester 0 wins.
        push(2, 8'h99, 1'b1);
        run_model();
        wait_cond(0, 1'b1, "t5_busy");
        repeat (3) @(negedge clk_100MHz);
        rst = 1'b1;
        @(negedge clk_100MHz);
        chk("t5_rst_grant", grant, 0);
        chk("t5_rst_start", tx_start, 0);
        chk("t5_rst_ack", ack, 0);
        rst = 1'b0;
        m_lo = N - 1;
        wait_cond(0, 1'b0, "t5_busy_fall");
        push(3, 8'hD3, 1'b1); push(0, 8'hD0, 1'b1); push(2, 8'hD2, 1'b1);
        run_model();
        chk("t5_model_first", exp_q[0], {3'd0, 8'hD0});
        wait_cond(1, 1'b1, "t5_start");
        chk("t5_first_grant", grant, 4'b0001);
        wait_drain("t5");

        // tx_busy never rises.
        tx_en = 1'b0;
        push(1, 8'hE1, 1'b1);
        run_model();
        wait_cond(1, 1'b1, "t6_start");
`ifdef UART_ARB_WDOG_EN
        err_exp++;
        t = 0;
        while (!err && t < 100) begin
            @(negedge clk_100MHz);
            t++;
        end
        chk("t6_wdog_len", t, WDOG_C);
        chk("t6_grant_at_err", grant, 0);
        @(negedge clk_100MHz);
        chk("t6_state_idle", state_dbg, 0);
`else
        repeat (40) @(negedge clk_100MHz);
        chk("t6_grant_stuck", grant, 4'b0010);
        chk("t6_state_wait_busy", state_dbg, 2);
`endif
        @(negedge clk_100MHz);
        chk("final_err_count", err_seen, err_exp);
        chk("final_exp_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
